// File: rtl/fpadd_arbiter.sv
// rtl/fpadd_arbiter.sv - round-robin arbiter sequencing one shared multi-cycle FP adder
module fpadd_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [32*NREQ-1:0]  req_a,
    input  logic [32*NREQ-1:0]  req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [31:0]         rsp_result,
    output logic                add_start,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    input  logic                add_done,
    input  logic [31:0]         add_result,
    output logic                busy,
    output logic                timeout_err
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   grant;
    logic [CW-1:0]   wd_cnt;
    logic [31:0]     result_q;

    logic            found;
    logic [GW-1:0]   win;
    logic [GW-1:0]   idx;
    logic [31:0]     a_sel;
    logic [31:0]     b_sel;
    logic            wd_expire;

    // Rotating priority search starting at ptr; first hit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = GW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == GW'(i)) begin
                a_sel = req_a[32*i +: 32];
                b_sel = req_b[32*i +: 32];
            end
        end
    end

    // A real completion on the expiry cycle wins over the watchdog.
    assign wd_expire   = (state == S_WAIT) && !add_done && (wd_cnt == CW'(TIMEOUT-1));
    assign timeout_err = wd_expire;
    assign req_ready   = (state == S_IDLE && found && !reset) ? (NREQ'(1) << win) : '0;
    assign rsp_valid   = (state == S_RESP) ? (NREQ'(1) << grant) : '0;
    assign rsp_result  = (state == S_RESP) ? result_q : '0;
    assign add_start   = (state == S_ISSUE);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            grant    <= '0;
            wd_cnt   <= '0;
            result_q <= '0;
            add_a    <= '0;
            add_b    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        add_a <= a_sel;
                        add_b <= b_sel;
                        grant <= win;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (add_done) begin
                        result_q <= add_result;
                        state    <= S_RESP;
                    end else if (wd_expire) begin
                        result_q <= QNAN;
                        state    <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[grant]) begin
                        ptr   <= (grant == GW'(NREQ-1)) ? '0 : grant + 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb/tb_fpadd_arbiter.sv - randomized and directed bench with a timeline reference model
module tb_fpadd_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic [31:0]         rsp_result, add_a, add_b, add_result;
    logic                add_start, add_done, busy, timeout_err;

    fpadd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_result(add_result),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: m_t counts cycles since acceptance (1 = launch cycle).
    bit          m_in, m_resp;
    int          m_t, m_g, m_ptr;
    logic [31:0] m_a, m_b, m_res;

    logic [NREQ-1:0] s_ready, s_rspv;
    logic [31:0]     s_res, s_adda, s_addb;
    logic            s_start, s_busy, s_to;

    bit          auto_req, auto_rsp, keep_valid;
    int          p_req = 30;
    int          adder_lat;
    int          cd = -1;
    logic [31:0] lat_a, lat_b;

    function automatic logic [31:0] adder_sum(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b;
    endfunction

    function automatic bit bit_at(input logic [NREQ-1:0] v, input int i);
        return v[i];
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic model_cycle();
        logic [NREQ-1:0] e_ready, e_rspv;
        logic [31:0]     e_res;
        logic            e_start, e_to;
        int              pick;
        cyc++;
        s_ready = req_ready; s_rspv = rsp_valid; s_res = rsp_result;
        s_adda = add_a; s_addb = add_b; s_start = add_start; s_busy = busy; s_to = timeout_err;
        if (reset) begin
            m_in = 0; m_resp = 0; m_ptr = 0; m_t = 0; m_g = 0;
            m_a = '0; m_b = '0; m_res = '0;
            return;
        end
        e_ready = '0; e_rspv = '0; e_res = '0; e_start = 1'b0; e_to = 1'b0; pick = -1;
        if (!m_in) begin
            for (int k = 0; k < NREQ; k++)
                if (pick < 0 && bit_at(req_valid, (m_ptr + k) % NREQ)) pick = (m_ptr + k) % NREQ;
            if (pick >= 0) e_ready = NREQ'(1) << pick;
        end else if (!m_resp) begin
            e_start = (m_t == 1);
            e_to    = (m_t == TIMEOUT + 1) && !add_done;
        end else begin
            e_rspv = NREQ'(1) << m_g;
            e_res  = m_res;
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rspv));
        chk("rsp_result", rsp_result, e_res);
        chk("add_start", 32'(add_start), 32'(e_start));
        chk("timeout_err", 32'(timeout_err), 32'(e_to));
        chk("busy", 32'(busy), 32'(m_in));
        chk("add_a", add_a, m_a);
        chk("add_b", add_b, m_b);
        if (!m_in) begin
            if (pick >= 0) begin
                m_in = 1; m_resp = 0; m_t = 1; m_g = pick;
                m_a = 32'(req_a >> (32*pick));
                m_b = 32'(req_b >> (32*pick));
            end
        end else if (!m_resp) begin
            if (m_t >= 2 && add_done) begin
                m_resp = 1; m_res = add_result;
            end else if (m_t == TIMEOUT + 1) begin
                m_resp = 1; m_res = QNAN;
            end
            m_t++;
        end else if (bit_at(rsp_ready, m_g)) begin
            m_in = 0; m_resp = 0; m_ptr = (m_g + 1) % NREQ;
        end
    endtask

    task automatic drive();
        if (s_start && adder_lat != 0) begin
            cd = (adder_lat < 0) ? int'($urandom_range(1, TIMEOUT + 2)) : adder_lat;
            lat_a = s_adda;
            lat_b = s_addb;
        end
        if (cd > 0) cd--;
        add_done   = (cd == 0);
        add_result = add_done ? adder_sum(lat_a, lat_b) : $urandom;
        if (cd == 0) cd = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (bit_at(s_ready, i) && bit_at(req_valid, i)) begin
                if (keep_valid) set_ops(i, $urandom, $urandom);
                else req_valid[i] = 1'b0;
            end else if (auto_req && !req_valid[i] && $urandom_range(0, 99) < p_req) begin
                req_valid[i] = 1'b1;
                set_ops(i, $urandom, $urandom);
            end
        end
        if (auto_rsp) rsp_ready = NREQ'($urandom) | NREQ'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string name, output int g);
        g = -1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (s_ready != '0) begin
                g = onehot_idx(s_ready);
                break;
            end
        end
        n_checks++;
        if (g < 0) begin
            n_errors++;
            $display("FAIL %s: no req_ready within 40 cycles", name);
        end
    endtask

    task automatic wait_rsp(input string name, output logic [31:0] res, output int to_seen);
        bit got;
        got = 0; to_seen = 0; res = 'x;
        for (int n = 0; n < 40; n++) begin
            step();
            if (s_to) to_seen++;
            if (s_rspv != '0) begin
                res = s_res;
                got = 1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s: no rsp_valid within 40 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 200; n++) begin
            step();
            if (!s_busy && s_ready == '0 && req_valid == '0) break;
        end
        chk(name, 32'(s_busy || s_ready != '0 || req_valid != '0), 32'd0);
    endtask

    initial begin
        int          g, c0, to_n, to_at, rsp_at, ng;
        int          grants[8];
        int          acc_cyc[8];
        logic [31:0] res;

        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        add_done = 1'b0; add_result = '0; lat_a = '0; lat_b = '0;
        auto_req = 0; auto_rsp = 0; keep_valid = 0; adder_lat = 3;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_rspv", 32'(s_rspv), 32'd0);
        chk("rst_result", s_res, 32'd0);
        chk("rst_add_a", s_adda, 32'd0);
        chk("rst_add_b", s_addb, 32'd0);
        chk("rst_start", 32'(s_start), 32'd0);
        chk("rst_timeout", 32'(s_to), 32'd0);

        // single op, adder latency 3
        rsp_ready = '1;
        set_ops(0, 32'h3F800000, 32'h40000000);
        req_valid[0] = 1'b1;
        step();
        chk("single_ready_c0", 32'(s_ready), 32'h1);
        step();
        chk("single_start_c1", 32'(s_start), 32'h1);
        chk("single_add_a", s_adda, 32'h3F800000);
        step(); step(); step();
        chk("single_no_rsp_c4", 32'(s_rspv), 32'h0);
        step();
        chk("single_rspv_c5", 32'(s_rspv), 32'h1);
        chk("single_result_c5", s_res, 32'h40400000);
        step();
        chk("single_idle_c6", 32'(s_busy), 32'h0);

        // fairness from ptr=0 with a 1-cycle adder
        do_reset();
        keep_valid = 1; adder_lat = 1; rsp_ready = '1;
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, $urandom, $urandom);
            req_valid[i] = 1'b1;
        end
        ng = 0;
        for (int n = 0; n < 60 && ng < 8; n++) begin
            step();
            if (s_ready != '0) begin
                grants[ng]  = onehot_idx(s_ready);
                acc_cyc[ng] = cyc;
                ng++;
            end
        end
        chk("fair_count", 32'(ng), 32'd8);
        for (int k = 0; k < 8; k++) chk("fair_order", 32'(grants[k]), 32'(k % 4));
        for (int k = 1; k < 8; k++) chk("fair_period", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd4);
        keep_valid = 0;
        drain("fair_drain");

        // backpressure on requester 2
        rsp_ready = '0; adder_lat = 3;
        set_ops(2, 32'h00001000, 32'h00000234);
        req_valid[2] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (s_rspv != '0) break;
        end
        chk("bp_rspv", 32'(s_rspv), 32'h4);
        chk("bp_result", s_res, 32'h00001234);
        set_ops(0, 32'h11, 32'h22); req_valid[0] = 1'b1;
        set_ops(1, 32'h33, 32'h44); req_valid[1] = 1'b1;
        rsp_ready = 4'b0010;
        for (int n = 0; n < 10; n++) begin
            step();
            chk("bp_hold_rspv", 32'(s_rspv), 32'h4);
            chk("bp_hold_result", s_res, 32'h00001234);
            chk("bp_no_ready", 32'(s_ready), 32'h0);
            chk("bp_no_start", 32'(s_start), 32'h0);
        end
        rsp_ready = 4'b0100;
        step();
        step();
        chk("bp_next_grant", 32'(s_ready), 32'h1);
        rsp_ready = '1;
        drain("bp_drain");

        // watchdog: adder never completes
        adder_lat = 0;
        set_ops(1, 32'h12345678, 32'h9ABCDEF0);
        req_valid[1] = 1'b1;
        wait_ready("to_accept", g);
        chk("to_grant", 32'(g), 32'd1);
        c0 = cyc; to_n = 0; to_at = -1; rsp_at = -1; res = '0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (s_to) begin to_n++; to_at = cyc - c0; end
            if (s_rspv != '0 && rsp_at < 0) begin rsp_at = cyc - c0; res = s_res; end
        end
        chk("to_pulses", 32'(to_n), 32'd1);
        chk("to_cycle", 32'(to_at), 32'd9);
        chk("to_rsp_cycle", 32'(rsp_at), 32'd10);
        chk("to_result", res, QNAN);
        adder_lat = 3;
        set_ops(1, 32'h00000100, 32'h00000023);
        req_valid[1] = 1'b1;
        wait_ready("recover_accept", g);
        wait_rsp("recover_rsp", res, to_n);
        chk("recover_result", res, 32'h00000123);
        chk("recover_no_to", 32'(to_n), 32'd0);
        drain("recover_drain");

        // stray add_done in IDLE and ISSUE
        add_done = 1'b1; add_result = 32'hDEADBEEF;
        step(); step();
        chk("stray_idle_busy", 32'(s_busy), 32'h0);
        adder_lat = 0;
        set_ops(0, 32'h1, 32'h2);
        req_valid[0] = 1'b1;
        wait_ready("stray_accept", g);
        add_done = 1'b1; add_result = 32'hDEADBEEF;
        wait_rsp("stray_rsp", res, to_n);
        chk("stray_issue_result", res, QNAN);
        chk("stray_issue_to", 32'(to_n), 32'd1);
        drain("stray_drain");

        // completion on the watchdog expiry cycle
        adder_lat = TIMEOUT;
        set_ops(3, 32'h00000500, 32'h00000006);
        req_valid[3] = 1'b1;
        wait_ready("simul_accept", g);
        wait_rsp("simul_rsp", res, to_n);
        chk("simul_result", res, 32'h00000506);
        chk("simul_no_to", 32'(to_n), 32'd0);
        drain("simul_drain");

        // reset in WAIT, late add_done afterwards
        adder_lat = 5;
        set_ops(2, 32'hAAAA0000, 32'h00005555);
        req_valid[2] = 1'b1;
        wait_ready("rw_accept", g);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            chk("rw_rspv", 32'(s_rspv), 32'h0);
            chk("rw_busy", 32'(s_busy), 32'h0);
            chk("rw_start", 32'(s_start), 32'h0);
            chk("rw_add_a", s_adda, 32'h0);
            chk("rw_result", s_res, 32'h0);
        end
        adder_lat = 2;
        set_ops(3, 32'h00000700, 32'h00000008);
        req_valid[3] = 1'b1;
        wait_ready("rw_next_accept", g);
        chk("rw_next_grant", 32'(g), 32'd3);
        wait_rsp("rw_next_rsp", res, to_n);
        chk("rw_next_result", res, 32'h00000708);
        drain("rw_drain");

        // randomized traffic, latencies, backpressure and occasional resets
        do_reset();
        auto_req = 1; auto_rsp = 1; adder_lat = -1;
        for (int n = 0; n < 3000; n++) begin
            step();
            reset = ($urandom_range(0, 399) == 0);
        end
        reset = 1'b0;
        auto_req = 0; auto_rsp = 0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
